pp_shift_accumulator: RTL

//  Downstream stage of the SD4 MAC partial-product generator. It consumes a stream of
//  (signed_pp, exp) terms and aligns each term: magnitude {1,m[2:0]} shifted left by exp,

---
 rtl/sd4_mac_pkg.sv | 17 +
 rtl/pp_term_aligner.sv | 25 ++
 rtl/pp_shift_accumulator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sd4_mac_pkg.sv
// Shared widths and field positions for the SD4 MAC partial-product datapath.
package sd4_mac_pkg;

  localparam int unsigned PP_W   = 5;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned MAG_W  = 4;
  localparam int unsigned TERM_W = 36;

  localparam int unsigned PP_SIGN = 4;
  localparam int unsigned PP_HID  = 3;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pp_term_aligner.sv
// Turns one {sign, hidden, m[2:0]} partial product and its shift into a signed aligned term.
module pp_term_aligner
  import sd4_mac_pkg::*;
(
  input  logic [PP_W-1:0]  signed_pp_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [TERM_W:0]  term_o
);

  logic [TERM_W-1:0] mag;
  logic [TERM_W:0]   mag_ext;

  always_comb begin
    mag     = '0;
    mag_ext = '0;
    term_o  = '0;
    // A cleared hidden bit encodes a zero term regardless of sign and mantissa.
    if (signed_pp_i[PP_HID]) begin
      mag     = TERM_W'({1'b1, signed_pp_i[MAG_W-2:0]}) << exp_i;
      mag_ext = {1'b0, mag};
      term_o  = signed_pp_i[PP_SIGN] ? (~mag_ext + 1'b1) : mag_ext;
    end
  end

endmodule

// File: rtl/pp_shift_accumulator.sv
// Two-stage term aligner and saturating group accumulator with a held valid/ready result.
module pp_shift_accumulator
  import sd4_mac_pkg::*;
#(
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [PP_W-1:0]    signed_pp,
  input  logic [EXP_W-1:0]   exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic [TERM_W:0]      term;
  logic [ACC_W-1:0]     term_ext;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  logic [ACC_W-1:0]     s1_term_q, s1_term_d;

  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 out_valid_q, out_valid_d;
  logic [ACC_W-1:0]     out_sum_q, out_sum_d;
  logic [COUNT_W-1:0]   out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 stall;
  logic                 take;
  logic [ACC_W:0]       sum_wide;
  logic                 ovf_now;
  logic [ACC_W-1:0]     sum_sat;
  logic [COUNT_W-1:0]   cnt_inc;

  pp_term_aligner u_aligner (
    .signed_pp_i (signed_pp),
    .exp_i       (exp),
    .term_o      (term)
  );

  assign term_ext = ACC_W'($signed(term));

  // Only a pending last term can collide with an unconsumed result.
  assign stall    = s1_valid_q & s1_last_q & out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign take     = s1_valid_q & ~stall;

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {s1_term_q[ACC_W-1], s1_term_q};
    ovf_now  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (ovf_now) begin
      sum_sat = sum_wide[ACC_W] ? AccMin : AccMax;
    end else begin
      sum_sat = sum_wide[ACC_W-1:0];
    end
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);
  end

  // Stage 1: aligned term register.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_term_d  = s1_term_q;
    if (in_valid && in_ready) begin
      s1_valid_d = 1'b1;
      s1_last_d  = in_last;
      s1_term_d  = term_ext;
    end else if (take) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: accumulator and output holding register.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (take) begin
      if (s1_last_q) begin
        out_valid_d = 1'b1;
        out_sum_d   = sum_sat;
        out_count_d = cnt_inc;
        out_ovf_d   = ovf_q | ovf_now;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | ovf_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_term_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_term_q   <= s1_term_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
